wb_trace_buffer: RTL and testbench

Synthesizable write-back trace capture block for the 5-stage MIPS pipeline. It replaces bench-side register printing with on-chip logging. It samples PC and qualifying register-file write-backs into a parametrised FIFO, tagging each record with a run-relative cycle index. It stops automatically after a programmable cycle budget, and entries are drained through a valid/ready read port.

---
 rtl/wb_trace_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_wb_trace_buffer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: on-chip write-back trace capture for the MIPS pipeline.
// Logs PC and qualifying register writes into a FIFO drained by valid/ready.
module wb_trace_buffer #(
  parameter int          DEPTH      = 16,
  parameter int          CYC_W      = 16,
  parameter int          MAX_CYCLES = 32,
  parameter logic [31:0] REG_MASK   = 32'h03FF_FF00
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode,
  input  logic [31:0]              pc,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_addr,
  input  logic [31:0]              wb_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [31:0]              rd_pc,
  output logic                     rd_wb,
  output logic [4:0]               rd_addr,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [15:0]              dropped
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [CYC_W-1:0] LAST_CYC =
    CYC_W'(MAX_CYCLES - 1);

  localparam bit LIMITED = (MAX_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CYC_W-1:0] cyc;

  logic [CYC_W-1:0] mem_cyc  [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic             mem_wb   [DEPTH];
  logic [4:0]       mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;

  logic running;
  logic launch;
  logic last;
  logic qual;
  logic req;
  logic full;
  logic pop;
  logic push;
  logic drop;

  logic [4:0]  rec_addr;
  logic [31:0] rec_data;

  // Control qualifiers shared by the FSM, counters and FIFO.
  always_comb begin
    running  = (state == S_RUN);
    launch   = start && !running;
    last     = LIMITED && (cyc == LAST_CYC);
    qual     = wb_valid && (wb_addr != 5'd0)
               && REG_MASK[wb_addr];
    req      = running && (mode || qual);
    full     = (cnt == FULL_CNT);
    pop      = rd_valid && rd_ready;
    push     = req && (!full || pop);
    drop     = req && full && !pop;
    rec_addr = qual ? wb_addr : 5'd0;
    rec_data = qual ? wb_data : 32'd0;
  end

  // Run-control next state; start beats stop outside RUN.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (stop || last) begin
          state_nx = S_DONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Run-control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Run-relative cycle index; wraps freely when unlimited.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc <= '0;
    end else if (launch) begin
      cyc <= '0;
    end else if (running) begin
      cyc <= cyc + CYC_W'(1);
    end
  end

  // Drop accounting, cleared at the start of every run.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
      dropped  <= 16'd0;
    end else if (launch) begin
      overflow <= 1'b0;
      dropped  <= 16'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped != 16'hFFFF) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

  // FIFO pointers and occupancy; push+pop at full keeps count.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Record storage; contents are only observed while count != 0.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_cyc[wptr]  <= cyc;
      mem_pc[wptr]   <= pc;
      mem_wb[wptr]   <= qual;
      mem_addr[wptr] <= rec_addr;
      mem_data[wptr] <= rec_data;
    end
  end

  // Head record presented combinationally, zeroed while empty.
  always_comb begin
    rd_valid = (cnt != '0);
    rd_cycle = '0;
    rd_pc    = 32'd0;
    rd_wb    = 1'b0;
    rd_addr  = 5'd0;
    rd_data  = 32'd0;
    if (rd_valid) begin
      rd_cycle = mem_cyc[rptr];
      rd_pc    = mem_pc[rptr];
      rd_wb    = mem_wb[rptr];
      rd_addr  = mem_addr[rptr];
      rd_data  = mem_data[rptr];
    end
  end

  // Status outputs.
  always_comb begin
    count = cnt;
    busy  = (state == S_RUN);
    done  = (state == S_DONE);
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed checks of wb_trace_buffer capture,
// overflow, masking, stop/restart and mid-run reset.
module tb_wb_trace_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_cycle;
  logic [31:0] rd_pc;
  logic        rd_wb;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] dropped;

  int vectors = 0;
  int miscompares = 0;

  wb_trace_buffer dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .pc       (pc),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_cycle (rd_cycle),
    .rd_pc    (rd_pc),
    .rd_wb    (rd_wb),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .dropped  (dropped)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [31:0] p, input logic v,
                      input logic [4:0] a, input logic [31:0] d,
                      input logic s);
    pc = p;
    wb_valid = v;
    wb_addr = a;
    wb_data = d;
    stop = s;
    tick();
    wb_valid = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
    stop = 1'b0;
  endtask

  task automatic pop1();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (count !== 5'd0 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_fifo: count=%0d rd_valid=%0b want 0/0",
               count, rd_valid);
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%0b done=%0b want 0/0",
               busy, done);
    end
    vectors++;
    if (overflow !== 1'b0 || dropped !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_drop: ovf=%0b dropped=%0d want 0/0",
               overflow, dropped);
    end
    vectors++;
    if (rd_cycle !== 16'd0 || rd_pc !== 32'd0 ||
        rd_data !== 32'd0 || rd_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_rd: cyc=%0d pc=%h data=%h addr=%0d want 0",
               rd_cycle, rd_pc, rd_data, rd_addr);
    end
  endtask

  task automatic test_capture();
    mode = 1'b0;
    kick();
    step(32'h00, 1'b0, 5'd0,  32'h0, 1'b0);
    step(32'h04, 1'b0, 5'd0,  32'h0, 1'b0);
    step(32'h08, 1'b1, 5'd16, 32'h5, 1'b0);
    step(32'h0C, 1'b1, 5'd0,  32'h7, 1'b0);
    step(32'h10, 1'b1, 5'd8,  32'h9, 1'b0);
    step(32'h14, 1'b0, 5'd0,  32'h0, 1'b1);
    vectors++;
    if (count !== 5'd2 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL cap_count: count=%0d done=%0b want 2/1",
               count, done);
    end
    vectors++;
    if (rd_cycle !== 16'd2 || rd_addr !== 5'd16 ||
        rd_data !== 32'h5 || rd_wb !== 1'b1 || rd_pc !== 32'h08) begin
      miscompares++;
      $display("FAIL cap_rec0: cyc=%0d addr=%0d data=%h pc=%h want 2/16/5/08",
               rd_cycle, rd_addr, rd_data, rd_pc);
    end
    pop1();
    vectors++;
    if (rd_cycle !== 16'd4 || rd_addr !== 5'd8 ||
        rd_data !== 32'h9 || rd_pc !== 32'h10) begin
      miscompares++;
      $display("FAIL cap_rec1: cyc=%0d addr=%0d data=%h pc=%h want 4/8/9/10",
               rd_cycle, rd_addr, rd_data, rd_pc);
    end
    pop1();
    vectors++;
    if (count !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin
      miscompares++;
      $display("FAIL cap_empty: count=%0d rd_valid=%0b data=%h want 0/0/0",
               count, rd_valid, rd_data);
    end
  endtask

  task automatic test_overflow();
    mode = 1'b1;
    kick();
    for (int c = 0; c < 32; c++) begin
      step(32'(c * 4), 1'b0, 5'd0, 32'd0, 1'b0);
      if (c == 15) begin
        vectors++;
        if (count !== 5'd16 || dropped !== 16'd0 || overflow !== 1'b0) begin
          miscompares++;
          $display("FAIL ovf_full: count=%0d dropped=%0d ovf=%0b want 16/0/0",
                   count, dropped, overflow);
        end
      end
      if (c == 16) begin
        vectors++;
        if (dropped !== 16'd1 || overflow !== 1'b1) begin
          miscompares++;
          $display("FAIL ovf_first: dropped=%0d ovf=%0b want 1/1",
                   dropped, overflow);
        end
      end
      if (c == 30) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL ovf_c30: busy=%0b done=%0b want 1/0", busy, done);
        end
      end
    end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_end: busy=%0b done=%0b want 0/1", busy, done);
    end
    vectors++;
    if (count !== 5'd16 || dropped !== 16'd16 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_totals: count=%0d dropped=%0d ovf=%0b want 16/16/1",
               count, dropped, overflow);
    end
    vectors++;
    if (rd_cycle !== 16'd0 || rd_pc !== 32'd0 || rd_wb !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_head: cyc=%0d pc=%h wb=%0b want 0/0/0",
               rd_cycle, rd_pc, rd_wb);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ec;
    logic [31:0] ep;
    mode = 1'b1;
    kick();
    vectors++;
    if (dropped !== 16'd0 || overflow !== 1'b0 || count !== 5'd16) begin
      miscompares++;
      $display("FAIL b2b_start: dropped=%0d ovf=%0b count=%0d want 0/0/16",
               dropped, overflow, count);
    end
    rd_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      vectors++;
      if (rd_cycle !== 16'(c) || rd_pc !== 32'(c * 4)) begin
        miscompares++;
        $display("FAIL b2b_head%0d: cyc=%0d pc=%h want %0d/%h",
                 c, rd_cycle, rd_pc, c, c * 4);
      end
      step(32'h200 + 32'(c * 4), 1'b0, 5'd0, 32'd0, c == 7);
      vectors++;
      if (count !== 5'd16 || dropped !== 16'd0) begin
        miscompares++;
        $display("FAIL b2b_cnt%0d: count=%0d dropped=%0d want 16/0",
                 c, count, dropped);
      end
    end
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        ec = 16'(i + 8);
        ep = 32'((i + 8) * 4);
      end else begin
        ec = 16'(i - 8);
        ep = 32'h200 + 32'((i - 8) * 4);
      end
      vectors++;
      if (rd_cycle !== ec || rd_pc !== ep) begin
        miscompares++;
        $display("FAIL b2b_drain%0d: cyc=%0d pc=%h want %0d/%h",
                 i, rd_cycle, rd_pc, ec, ep);
      end
      pop1();
    end
    vectors++;
    if (rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_empty: rd_valid=%0b want 0", rd_valid);
    end
  endtask

  task automatic test_mask();
    mode = 1'b0;
    kick();
    step(32'h0, 1'b0, 5'd0,  32'h0,      1'b0);
    step(32'h4, 1'b1, 5'd29, 32'hDEAD,   1'b0);
    step(32'h8, 1'b1, 5'd9,  32'h1234,   1'b0);
    step(32'hC, 1'b1, 5'd31, 32'hBEEF,   1'b1);
    vectors++;
    if (count !== 5'd1 || rd_cycle !== 16'd2 ||
        rd_addr !== 5'd9 || rd_data !== 32'h1234) begin
      miscompares++;
      $display("FAIL mask_m0: count=%0d cyc=%0d addr=%0d data=%h want 1/2/9/1234",
               count, rd_cycle, rd_addr, rd_data);
    end
    pop1();
    mode = 1'b1;
    kick();
    step(32'h40, 1'b1, 5'd29, 32'hDEAD, 1'b0);
    step(32'h44, 1'b1, 5'd31, 32'hBEEF, 1'b1);
    vectors++;
    if (count !== 5'd2 || rd_cycle !== 16'd0 || rd_pc !== 32'h40 ||
        rd_wb !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
      miscompares++;
      $display("FAIL mask_sp: count=%0d cyc=%0d pc=%h wb=%0b addr=%0d data=%h",
               count, rd_cycle, rd_pc, rd_wb, rd_addr, rd_data);
    end
    pop1();
    vectors++;
    if (rd_cycle !== 16'd1 || rd_wb !== 1'b0 || rd_data !== 32'd0) begin
      miscompares++;
      $display("FAIL mask_ra: cyc=%0d wb=%0b data=%h want 1/0/0",
               rd_cycle, rd_wb, rd_data);
    end
    pop1();
  endtask

  task automatic test_stop_restart();
    logic [15:0] ec;
    mode = 1'b1;
    kick();
    for (int c = 0; c < 6; c++) begin
      start = (c == 2);
      step(32'(c * 4), 1'b0, 5'd0, 32'd0, c == 5);
      start = 1'b0;
    end
    vectors++;
    if (count !== 5'd6 || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_state: count=%0d done=%0b busy=%0b want 6/1/0",
               count, done, busy);
    end
    stop = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    vectors++;
    if (count !== 5'd6 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL stop_idle: count=%0d done=%0b want 6/1", count, done);
    end
    kick();
    step(32'h80, 1'b0, 5'd0, 32'd0, 1'b0);
    step(32'h84, 1'b0, 5'd0, 32'd0, 1'b1);
    vectors++;
    if (count !== 5'd8) begin
      miscompares++;
      $display("FAIL restart_keep: count=%0d want 8", count);
    end
    for (int i = 0; i < 8; i++) begin
      ec = (i < 6) ? 16'(i) : 16'(i - 6);
      vectors++;
      if (rd_cycle !== ec) begin
        miscompares++;
        $display("FAIL restart_rec%0d: cyc=%0d want %0d", i, rd_cycle, ec);
      end
      pop1();
    end
  endtask

  task automatic test_reset_midrun();
    mode = 1'b1;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_wins: busy=%0b want 1", busy);
    end
    step(32'h0, 1'b0, 5'd0, 32'd0, 1'b0);
    step(32'h4, 1'b0, 5'd0, 32'd0, 1'b0);
    step(32'h8, 1'b0, 5'd0, 32'd0, 1'b0);
    vectors++;
    if (count !== 5'd3 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: count=%0d busy=%0b want 3/1", count, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (count !== 5'd0 || rd_valid !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || dropped !== 16'd0) begin
      miscompares++;
      $display("FAIL mid_reset: count=%0d rdv=%0b busy=%0b done=%0b drop=%0d",
               count, rd_valid, busy, done, dropped);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_back_to_back();
    test_mask();
    test_stop_restart();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
